// File: rtl/mac_lane_pipe.sv
// mac_lane_pipe: multi-lane pipelined signed multiply-accumulate.
// LANES independent MACs share one valid/first/last control stream. Stage 1
// registers the per-lane products and the frame bias; stage 2 accumulates
// and publishes the frame result on the last beat.
// Optional build macro: MAC_SAT_EN -- saturating stage-2 adds plus a per-lane
// sticky clamp flag reported on sat. Without it the adds wrap and sat is 0.
module mac_lane_pipe #(
    parameter int VAR_SIZE = 8,
    parameter int ACC_SIZE = 32,
    parameter int LANES    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [LANES*VAR_SIZE-1:0] a,
    input  logic [LANES*VAR_SIZE-1:0] b,
    input  logic [LANES*ACC_SIZE-1:0] bias,
    output logic                      out_valid,
    output logic [LANES*ACC_SIZE-1:0] acc_out,
    output logic [LANES-1:0]          sat
);

    logic r_s1_valid;
    logic r_s1_first;
    logic r_s1_last;
    logic r_out_valid;

    // Stage-1 control flags; first/last only count when the beat is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_first <= in_valid & in_first;
            r_s1_last  <= in_valid & in_last;
        end
    end

    // Result strobe: one cycle after the last beat leaves stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid & r_s1_last;
        end
    end

    assign out_valid = r_out_valid;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [VAR_SIZE-1:0]   w_a;
        logic signed [VAR_SIZE-1:0]   w_b;
        logic signed [2*VAR_SIZE-1:0] w_prod;
        logic signed [ACC_SIZE-1:0]   w_base;
        logic signed [ACC_SIZE-1:0]   w_sum;
        logic signed [ACC_SIZE-1:0]   r_p;
        logic signed [ACC_SIZE-1:0]   r_bias;
        logic signed [ACC_SIZE-1:0]   r_acc;
        logic signed [ACC_SIZE-1:0]   r_acc_out;

        assign w_a    = a[gi*VAR_SIZE +: VAR_SIZE];
        assign w_b    = b[gi*VAR_SIZE +: VAR_SIZE];
        assign w_prod = (2*VAR_SIZE)'(w_a) * (2*VAR_SIZE)'(w_b);

        // A first beat restarts from the bias; otherwise continue the running sum.
        assign w_base = r_s1_first ? r_bias : r_acc;

        // Stage 1: full-precision product, sign-extended; bias latched on first beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_p    <= '0;
                r_bias <= '0;
            end else begin
                r_p <= ACC_SIZE'(w_prod);
                if (in_valid && in_first) begin
                    r_bias <= bias[gi*ACC_SIZE +: ACC_SIZE];
                end
            end
        end

`ifdef MAC_SAT_EN
        localparam logic signed [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
        localparam logic signed [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

        logic signed [ACC_SIZE:0] w_wide;
        logic                     w_ovf;
        logic                     w_sticky_nxt;
        logic                     r_sticky;
        logic                     r_sat;

        // One guard bit exposes overflow; its sign picks the clamp direction.
        assign w_wide       = (ACC_SIZE+1)'(w_base) + (ACC_SIZE+1)'(r_p);
        assign w_ovf        = w_wide[ACC_SIZE] ^ w_wide[ACC_SIZE-1];
        assign w_sum        = w_ovf ? (w_wide[ACC_SIZE] ? ACC_MIN : ACC_MAX)
                                    : w_wide[ACC_SIZE-1:0];
        assign w_sticky_nxt = (r_s1_first ? 1'b0 : r_sticky) | w_ovf;

        // Sticky clamp flag per frame, published alongside the result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sticky <= 1'b0;
                r_sat    <= 1'b0;
            end else if (r_s1_valid) begin
                r_sticky <= w_sticky_nxt;
                if (r_s1_last) begin
                    r_sat <= w_sticky_nxt;
                end
            end
        end

        assign sat[gi] = r_sat;
`else
        assign w_sum   = w_base + r_p;
        assign sat[gi] = 1'b0;
`endif

        // Stage 2: accumulate valid beats, hold across bubbles, publish on last.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc     <= '0;
                r_acc_out <= '0;
            end else if (r_s1_valid) begin
                r_acc <= w_sum;
                if (r_s1_last) begin
                    r_acc_out <= w_sum;
                end
            end
        end

        assign acc_out[gi*ACC_SIZE +: ACC_SIZE] = r_acc_out;
    end

endmodule

// File: tb/tb_mac_lane_pipe.sv
// Directed bench for mac_lane_pipe: a default 32-bit accumulator instance and
// a 16-bit accumulator instance for the overflow cases. Expectations for the
// 16-bit overflow frame follow MAC_SAT_EN.
module tb_mac_lane_pipe;

    localparam int V   = 8;
    localparam int A   = 32;
    localparam int A16 = 16;
    localparam int L   = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_first, in_last;

    logic signed [V-1:0]   ta [L];
    logic signed [V-1:0]   tbv[L];
    logic signed [A-1:0]   tbias[L];
    logic signed [A16-1:0] tbias16[L];

    logic [L*V-1:0]   a, b;
    logic [L*A-1:0]   bias;
    logic [L*A16-1:0] bias16;

    logic             out_valid, out_valid16;
    logic [L*A-1:0]   acc_out;
    logic [L*A16-1:0] acc_out16;
    logic [L-1:0]     sat, sat16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        a      = '0;
        b      = '0;
        bias   = '0;
        bias16 = '0;
        for (int i = 0; i < L; i++) begin
            a[i*V +: V]        = ta[i];
            b[i*V +: V]        = tbv[i];
            bias[i*A +: A]     = tbias[i];
            bias16[i*A16 +: A16] = tbias16[i];
        end
    end

    mac_lane_pipe #(.VAR_SIZE(V), .ACC_SIZE(A), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .a(a), .b(b), .bias(bias),
        .out_valid(out_valid), .acc_out(acc_out), .sat(sat)
    );

    mac_lane_pipe #(.VAR_SIZE(V), .ACC_SIZE(A16), .LANES(L)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .a(a), .b(b), .bias(bias16),
        .out_valid(out_valid16), .acc_out(acc_out16), .sat(sat16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_l0"}, acc_out[0*A +: A], e0);
        chk({tag, "_l1"}, acc_out[1*A +: A], e1);
        chk({tag, "_l2"}, acc_out[2*A +: A], e2);
        chk({tag, "_l3"}, acc_out[3*A +: A], e3);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Idle cycle; first/last are deliberately set to prove they are gated by valid.
    task automatic idle;
        in_valid = 1'b0;
        in_first = 1'b1;
        in_last  = 1'b1;
    endtask

    task automatic set_lane(input int i, input int av, input int bv, input int bi);
        ta[i]      = V'(av);
        tbv[i]     = V'(bv);
        tbias[i]   = bi;
        tbias16[i] = A16'(bi);
    endtask

    task automatic set_all(input int av, input int bv, input int bi);
        for (int i = 0; i < L; i++) set_lane(i, av, bv, bi);
    endtask

    task automatic beat(input logic f, input logic l);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
    endtask

    // Three-beat dot-product frame with distinct per-lane data and optional bubbles.
    task automatic frame3(input string tag, input int gap);
        int fa[L][3];
        int fb[L][3];
        int fbias[L];
        fa    = '{'{2, -4, 7}, '{1, 2, 3}, '{-128, 0, 10}, '{127, 127, -1}};
        fb    = '{'{3, 5, -1}, '{1, 2, 3}, '{127, 5, 10},  '{127, 127, 1}};
        fbias = '{10, -5, 1000, 0};
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < L; i++) set_lane(i, fa[i][k], fb[i][k], (k == 0) ? fbias[i] : 7777);
            beat(k == 0, k == 2);
            tick();
            if (k < 2) begin
                for (int g = 0; g < gap; g++) begin
                    idle();
                    tick();
                end
            end
        end
        idle();
        chk({tag, "_ov_t1"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_ov_t2"}, 32'(out_valid), 32'd1);
        chk_lanes(tag, -11, 9, -15156, 32257);
        chk({tag, "_sat"}, 32'(sat), 32'd0);
        tick();
        chk({tag, "_ov_t3"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        set_all(0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk_lanes("rst_acc", 0, 0, 0, 0);
        chk("rst_sat", 32'(sat), 32'd0);

        // Dot product, contiguous then with two-cycle bubbles between beats.
        frame3("dot", 0);
        frame3("bubble", 2);

        // Single-beat frame at the operand extremes.
        set_all(-128, -128, 0);
        beat(1'b1, 1'b1);
        tick();
        idle();
        tick();
        chk("single_ov", 32'(out_valid), 32'd1);
        chk_lanes("single", 16384, 16384, 16384, 16384);

        // first mid-frame restarts; bias on a non-first beat is ignored.
        set_all(5, 5, 50);
        beat(1'b1, 1'b0);
        tick();
        set_all(1, 1, 2);
        beat(1'b1, 1'b0);
        tick();
        set_all(3, 1, 999);
        beat(1'b0, 1'b1);
        tick();
        idle();
        tick();
        chk("restart_ov", 32'(out_valid), 32'd1);
        chk_lanes("restart", 6, 6, 6, 6);

        // Back-to-back single-beat frames.
        set_all(1, 1, 1);
        beat(1'b1, 1'b1);
        tick();
        set_all(2, 2, 100);
        beat(1'b1, 1'b1);
        tick();
        idle();
        chk("b2b_ovA", 32'(out_valid), 32'd1);
        chk_lanes("b2bA", 2, 2, 2, 2);
        tick();
        chk("b2b_ovB", 32'(out_valid), 32'd1);
        chk_lanes("b2bB", 104, 104, 104, 104);
        tick();
        chk("b2b_ov_end", 32'(out_valid), 32'd0);

        // Overflow on the 16-bit accumulator instance, then a clean frame.
        set_all(1, 1, 32767);
        beat(1'b1, 1'b1);
        tick();
        set_all(1, 1, 0);
        beat(1'b1, 1'b1);
        tick();
        idle();
        chk("ovf_ov16", 32'(out_valid16), 32'd1);
`ifdef MAC_SAT_EN
        chk("ovf_acc16_l0", 32'(acc_out16[0*A16 +: A16]), 32'h7fff);
        chk("ovf_acc16_l3", 32'(acc_out16[3*A16 +: A16]), 32'h7fff);
        chk("ovf_sat16", 32'(sat16), 32'hf);
`else
        chk("ovf_acc16_l0", 32'(acc_out16[0*A16 +: A16]), 32'h8000);
        chk("ovf_acc16_l3", 32'(acc_out16[3*A16 +: A16]), 32'h8000);
        chk("ovf_sat16", 32'(sat16), 32'h0);
`endif
        chk_lanes("ovf_wide", 32768, 32768, 32768, 32768);
        tick();
        chk("next_ov16", 32'(out_valid16), 32'd1);
        chk("next_acc16_l0", 32'(acc_out16[0*A16 +: A16]), 32'h0001);
        chk("next_acc16_l2", 32'(acc_out16[2*A16 +: A16]), 32'h0001);
        chk("next_sat16", 32'(sat16), 32'h0);
        tick();

        // Asynchronous reset mid-frame while a result is being presented.
        set_all(2, 2, 0);
        beat(1'b1, 1'b1);
        tick();
        set_all(3, 3, 7);
        beat(1'b1, 1'b0);
        tick();
        chk("prerst_ov", 32'(out_valid), 32'd1);
        chk_lanes("prerst", 4, 4, 4, 4);
        set_all(4, 4, 7);
        beat(1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", 32'(out_valid), 32'd0);
        chk_lanes("arst", 0, 0, 0, 0);
        chk("arst_sat16", 32'(sat16), 32'd0);
        @(negedge clk);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_ov", 32'(out_valid), 32'd0);
        end

        // Beat with no preceding first accumulates onto zero.
        set_all(2, 3, 55);
        beat(1'b0, 1'b1);
        tick();
        idle();
        tick();
        chk("nofirst_ov", 32'(out_valid), 32'd1);
        chk_lanes("nofirst", 6, 6, 6, 6);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
